// File: rtl/mod_pkg.sv
// Shared encodings, FSM state constants and scale-factor helper for the PUSCH
// modulation mapper.
package mod_pkg;

  localparam logic [3:0] MOD_BPSK   = 4'd1;
  localparam logic [3:0] MOD_QPSK   = 4'd2;
  localparam logic [3:0] MOD_QAM16  = 4'd4;
  localparam logic [3:0] MOD_QAM64  = 4'd6;
  localparam logic [3:0] MOD_QAM256 = 4'd8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_CLOSE = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  function automatic logic order_ok(input logic [3:0] ord);
    return (ord == MOD_BPSK) || (ord == MOD_QPSK) || (ord == MOD_QAM16) ||
           (ord == MOD_QAM64) || (ord == MOD_QAM256);
  endfunction

  // round(2^frac / sqrt(norm)), derived from a Q0.20 table; valid for frac <= 19
  function automatic int k_scale(input logic [3:0] ord, input int frac);
    int base;
    case (ord)
      MOD_BPSK, MOD_QPSK: base = 741455;
      MOD_QAM16:          base = 331589;
      MOD_QAM64:          base = 161799;
      MOD_QAM256:         base = 80422;
      default:            base = 0;
    endcase
    return (base + (1 << (19 - frac))) >>> (20 - frac);
  endfunction

endpackage

// File: rtl/gray_pam_axis.sv
// One axis of the Gray-coded PAM mapping; bits[k] is the k-th bit feeding this
// axis (b0,b2,b4,b6 for I). Output is the integer amplitude.
module gray_pam_axis
  import mod_pkg::*;
(
  input  logic [3:0]        bits,
  input  logic [3:0]        ord,
  output logic signed [4:0] amp
);

  int s0, s1, s2, s3, a;

  always_comb begin
    s0 = bits[0] ? -1 : 1;
    s1 = bits[1] ? -1 : 1;
    s2 = bits[2] ? -1 : 1;
    s3 = bits[3] ? -1 : 1;
    case (ord)
      MOD_BPSK, MOD_QPSK: a = s0;
      MOD_QAM16:          a = s0 * (2 - s1);
      MOD_QAM64:          a = s0 * (4 - s1 * (2 - s2));
      MOD_QAM256:         a = s0 * (8 - s1 * (4 - s2 * (2 - s3)));
      default:            a = 0;
    endcase
    amp = 5'(a);
  end

endmodule

// File: rtl/mod_mapper_pp.sv
// Serial-bit modulation mapper writing scaled I/Q symbols into a ping-pong
// buffer, with bank backpressure and block-completion reporting.
module mod_mapper_pp
  import mod_pkg::*;
#(
  parameter int OUT_WIDTH  = 18,
  parameter int FRAC_BITS  = 10,
  parameter int MAX_SYMS   = 1200,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                         CLK_Mod,
  input  logic                         RST_Mod,
  input  logic                         Valid_Mod_IN,
  input  logic                         Bit_IN,
  input  logic [3:0]                   Order_Mod,
  input  logic [1:0]                   Bank_Free,
  output logic                         Ready_Mod_OUT,
  output logic                         Mod_Valid_OUT,
  output logic signed [OUT_WIDTH-1:0]  Mod_OUT_I,
  output logic signed [OUT_WIDTH-1:0]  Mod_OUT_Q,
  output logic [ADDR_WIDTH-1:0]        Wr_addr,
  output logic                         Bank_Sel,
  output logic                         MOD_DONE,
  output logic [ADDR_WIDTH-1:0]        Sym_Count,
  output logic                         Order_Err
);

  localparam int PW = FRAC_BITS + 6;
  localparam logic [FRAC_BITS-1:0] K_QPSK   = FRAC_BITS'(k_scale(MOD_QPSK, FRAC_BITS));
  localparam logic [FRAC_BITS-1:0] K_QAM16  = FRAC_BITS'(k_scale(MOD_QAM16, FRAC_BITS));
  localparam logic [FRAC_BITS-1:0] K_QAM64  = FRAC_BITS'(k_scale(MOD_QAM64, FRAC_BITS));
  localparam logic [FRAC_BITS-1:0] K_QAM256 = FRAC_BITS'(k_scale(MOD_QAM256, FRAC_BITS));

  if (OUT_WIDTH < FRAC_BITS + 5) begin : g_chk_width
    $error("mod_mapper_pp: OUT_WIDTH must be >= FRAC_BITS+5");
  end
  if (FRAC_BITS > 19) begin : g_chk_frac
    $error("mod_mapper_pp: FRAC_BITS must be <= 19");
  end
  if ((1 << ADDR_WIDTH) < MAX_SYMS + 1) begin : g_chk_addr
    $error("mod_mapper_pp: ADDR_WIDTH too small for MAX_SYMS");
  end

  state_t                state;
  logic [3:0]            ord_r, cur_ord;
  logic [2:0]            bit_cnt;
  logic [7:0]            sym_bits, bits_nxt;
  logic [ADDR_WIDTH-1:0] sym_cnt;
  logic                  ready, xfer, sym_done, last_sym;
  logic [3:0]            i_bits, q_bits;
  logic signed [4:0]     amp_i, amp_q;
  logic [FRAC_BITS-1:0]  k_cur;
  logic signed [PW-1:0]  k_ext, prod_i, prod_q;

  // Order is taken live on the first bit of a block, then held in ord_r
  assign cur_ord = (state == ST_IDLE) ? Order_Mod : ord_r;

  // A bank wrap leaves the block empty; hold off until the new bank is released
  always_comb begin
    ready = 1'b0;
    case (state)
      ST_IDLE:  ready = Bank_Free[Bank_Sel];
      ST_RUN:   ready = (sym_cnt != '0) || (bit_cnt != '0) || Bank_Free[Bank_Sel];
      ST_DRAIN: ready = 1'b1;
      default:  ready = 1'b0;
    endcase
  end
  assign Ready_Mod_OUT = ready & RST_Mod;
  assign xfer          = Valid_Mod_IN & Ready_Mod_OUT;

  always_comb begin
    bits_nxt          = sym_bits;
    bits_nxt[bit_cnt] = Bit_IN;
  end

  assign sym_done = xfer && ((state == ST_IDLE) || (state == ST_RUN)) &&
                    order_ok(cur_ord) && (4'(bit_cnt) == cur_ord - 4'd1);
  assign last_sym = sym_done && (sym_cnt == ADDR_WIDTH'(MAX_SYMS - 1));

  assign i_bits = {bits_nxt[6], bits_nxt[4], bits_nxt[2], bits_nxt[0]};
  assign q_bits = (cur_ord == MOD_BPSK) ? {3'b000, bits_nxt[0]}
                                        : {bits_nxt[7], bits_nxt[5], bits_nxt[3], bits_nxt[1]};

  gray_pam_axis u_axis_i (.bits(i_bits), .ord(cur_ord), .amp(amp_i));
  gray_pam_axis u_axis_q (.bits(q_bits), .ord(cur_ord), .amp(amp_q));

  always_comb begin
    case (cur_ord)
      MOD_QAM16:  k_cur = K_QAM16;
      MOD_QAM64:  k_cur = K_QAM64;
      MOD_QAM256: k_cur = K_QAM256;
      default:    k_cur = K_QPSK;
    endcase
  end

  assign k_ext  = PW'(k_cur);
  assign prod_i = PW'(amp_i) * k_ext;
  assign prod_q = PW'(amp_q) * k_ext;

  assign MOD_DONE  = (state == ST_CLOSE);
  assign Sym_Count = MOD_DONE ? sym_cnt : '0;

  always_ff @(posedge CLK_Mod or negedge RST_Mod) begin
    if (!RST_Mod) begin
      state         <= ST_IDLE;
      ord_r         <= '0;
      bit_cnt       <= '0;
      sym_bits      <= '0;
      sym_cnt       <= '0;
      Bank_Sel      <= 1'b0;
      Mod_Valid_OUT <= 1'b0;
      Mod_OUT_I     <= '0;
      Mod_OUT_Q     <= '0;
      Wr_addr       <= '0;
      Order_Err     <= 1'b0;
    end else begin
      Mod_Valid_OUT <= 1'b0;
      if (sym_done) begin
        Mod_Valid_OUT <= 1'b1;
        Mod_OUT_I     <= OUT_WIDTH'(prod_i);
        Mod_OUT_Q     <= OUT_WIDTH'(prod_q);
        Wr_addr       <= sym_cnt;
        sym_cnt       <= sym_cnt + ADDR_WIDTH'(1);
      end
      case (state)
        ST_IDLE: if (xfer) begin
          ord_r <= Order_Mod;
          if (!order_ok(Order_Mod)) begin
            Order_Err <= 1'b1;
            state     <= ST_DRAIN;
          end else begin
            sym_bits <= bits_nxt;
            bit_cnt  <= sym_done ? 3'd0 : 3'd1;
            state    <= last_sym ? ST_CLOSE : ST_RUN;
          end
        end
        ST_RUN: if (xfer) begin
          sym_bits <= bits_nxt;
          bit_cnt  <= sym_done ? 3'd0 : bit_cnt + 3'd1;
          if (last_sym) state <= ST_CLOSE;
        end else if (!Valid_Mod_IN) begin
          // partial symbol is dropped; an empty block closes silently
          if (bit_cnt != '0) Order_Err <= 1'b1;
          bit_cnt <= '0;
          state   <= (sym_cnt != '0) ? ST_CLOSE : ST_IDLE;
        end
        ST_CLOSE: begin
          Bank_Sel <= ~Bank_Sel;
          sym_cnt  <= '0;
          bit_cnt  <= '0;
          state    <= Valid_Mod_IN ? ST_RUN : ST_IDLE;
        end
        default: if (!Valid_Mod_IN) state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mapper_pp.sv
// Directed bench for mod_mapper_pp (MAX_SYMS=4 so block wrap is reachable).
module tb_mod_mapper_pp;

  logic               CLK_Mod = 1'b0;
  logic               RST_Mod = 1'b0;
  logic               Valid_Mod_IN = 1'b0;
  logic               Bit_IN = 1'b0;
  logic [3:0]         Order_Mod = 4'd0;
  logic [1:0]         Bank_Free = 2'b11;
  logic               Ready_Mod_OUT, Mod_Valid_OUT, Bank_Sel, MOD_DONE, Order_Err;
  logic signed [17:0] Mod_OUT_I, Mod_OUT_Q;
  logic [10:0]        Wr_addr, Sym_Count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] got, exp;

  localparam logic signed [17:0] P724  = 18'sd724;
  localparam logic signed [17:0] N724  = -18'sd724;
  localparam logic signed [17:0] P324  = 18'sd324;
  localparam logic signed [17:0] N972  = -18'sd972;
  localparam logic signed [17:0] P1106 = 18'sd1106;
  localparam logic signed [17:0] N1185 = -18'sd1185;

  mod_mapper_pp #(.OUT_WIDTH(18), .FRAC_BITS(10), .MAX_SYMS(4), .ADDR_WIDTH(11)) dut (
    .CLK_Mod(CLK_Mod), .RST_Mod(RST_Mod), .Valid_Mod_IN(Valid_Mod_IN), .Bit_IN(Bit_IN),
    .Order_Mod(Order_Mod), .Bank_Free(Bank_Free), .Ready_Mod_OUT(Ready_Mod_OUT),
    .Mod_Valid_OUT(Mod_Valid_OUT), .Mod_OUT_I(Mod_OUT_I), .Mod_OUT_Q(Mod_OUT_Q),
    .Wr_addr(Wr_addr), .Bank_Sel(Bank_Sel), .MOD_DONE(MOD_DONE), .Sym_Count(Sym_Count),
    .Order_Err(Order_Err)
  );

  always #5 CLK_Mod = ~CLK_Mod;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Presents one bit at a negedge, waits (bounded) for Ready, returns at the
  // negedge after the accepting posedge.
  task automatic send_bit(input logic b);
    int n = 0;
    Valid_Mod_IN = 1'b1;
    Bit_IN       = b;
    #1;
    while (!Ready_Mod_OUT && n < 50) begin
      @(negedge CLK_Mod); #1; n++;
    end
    n_checks++;
    if (!Ready_Mod_OUT) begin
      n_fail++;
      $display("FAIL ready_timeout got ready=%0b exp 1", Ready_Mod_OUT);
    end
    @(negedge CLK_Mod);
  endtask

  task automatic send_bits(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) send_bit(bits[i]);
  endtask

  task automatic apply_reset();
    @(negedge CLK_Mod);
    RST_Mod = 1'b0; Valid_Mod_IN = 1'b0; Bank_Free = 2'b11;
    repeat (2) @(negedge CLK_Mod);
    RST_Mod = 1'b1;
    @(negedge CLK_Mod);
  endtask

  task automatic test_reset();
    #1;
    got = {Ready_Mod_OUT, Mod_Valid_OUT, Mod_OUT_I, Mod_OUT_Q, Wr_addr, Bank_Sel};
    exp = '0;
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_outputs got=%h exp=%h", got, exp); end
    got = {MOD_DONE, Sym_Count, Order_Err};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_status got=%h exp=%h", got, exp); end
    @(negedge CLK_Mod);
    RST_Mod = 1'b1;
    @(negedge CLK_Mod);
  endtask

  task automatic test_qpsk();
    Order_Mod = 4'd2;
    send_bits(8'b00, 2);
    got = {Mod_Valid_OUT, Mod_OUT_I, Mod_OUT_Q, Wr_addr, Bank_Sel};
    exp = {1'b1, P724, P724, 11'd0, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL qpsk_sym0 got=%h exp=%h", got, exp); end
    send_bits(8'b11, 2);
    got = {Mod_Valid_OUT, Mod_OUT_I, Mod_OUT_Q, Wr_addr, Bank_Sel};
    exp = {1'b1, N724, N724, 11'd1, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL qpsk_sym1 got=%h exp=%h", got, exp); end
    Valid_Mod_IN = 1'b0;
    @(negedge CLK_Mod);
    got = {MOD_DONE, Sym_Count, Bank_Sel};
    exp = {1'b1, 11'd2, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL qpsk_done got=%h exp=%h", got, exp); end
    @(negedge CLK_Mod);
    got = {MOD_DONE, Bank_Sel};
    exp = {1'b0, 1'b1};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL qpsk_toggle got=%h exp=%h", got, exp); end
  endtask

  task automatic test_16qam();
    Order_Mod = 4'd4;
    send_bits(8'b0000, 4);
    got = {Mod_Valid_OUT, Mod_OUT_I, Mod_OUT_Q, Wr_addr, Bank_Sel};
    exp = {1'b1, P324, P324, 11'd0, 1'b1};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL qam16_sym0 got=%h exp=%h", got, exp); end
    send_bits(8'b1111, 4);
    got = {Mod_Valid_OUT, Mod_OUT_I, Mod_OUT_Q, Wr_addr, Bank_Sel};
    exp = {1'b1, N972, N972, 11'd1, 1'b1};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL qam16_sym1 got=%h exp=%h", got, exp); end
    Valid_Mod_IN = 1'b0;
    @(negedge CLK_Mod);
    got = {MOD_DONE, Sym_Count, Bank_Sel};
    exp = {1'b1, 11'd2, 1'b1};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL qam16_done got=%h exp=%h", got, exp); end
    @(negedge CLK_Mod);
  endtask

  task automatic test_64qam();
    Order_Mod = 4'd6;
    send_bits(8'b0011_1100, 6);
    got = {Mod_Valid_OUT, Mod_OUT_I, Mod_OUT_Q, Wr_addr, Bank_Sel};
    exp = {1'b1, P1106, P1106, 11'd0, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL qam64_sym got=%h exp=%h", got, exp); end
    Valid_Mod_IN = 1'b0;
    repeat (2) @(negedge CLK_Mod);
  endtask

  task automatic test_256qam();
    Order_Mod = 4'd8;
    send_bits(8'hFF, 7);
    n_checks++;
    if (Mod_Valid_OUT !== 1'b0) begin n_fail++; $display("FAIL qam256_early got=%0b exp=0", Mod_Valid_OUT); end
    send_bit(1'b1);
    got = {Mod_Valid_OUT, Mod_OUT_I, Mod_OUT_Q, Wr_addr, Bank_Sel};
    exp = {1'b1, N1185, N1185, 11'd0, 1'b1};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL qam256_sym got=%h exp=%h", got, exp); end
    Valid_Mod_IN = 1'b0;
    repeat (2) @(negedge CLK_Mod);
  endtask

  task automatic test_bpsk();
    Order_Mod = 4'd1;
    Valid_Mod_IN = 1'b1; Bit_IN = 1'b1;
    #1;
    n_checks++;
    if (Mod_Valid_OUT !== 1'b0) begin n_fail++; $display("FAIL bpsk_pre got=%0b exp=0", Mod_Valid_OUT); end
    @(negedge CLK_Mod);
    Valid_Mod_IN = 1'b0;
    got = {Mod_Valid_OUT, Mod_OUT_I, Mod_OUT_Q, Wr_addr, Bank_Sel};
    exp = {1'b1, N724, N724, 11'd0, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL bpsk_sym got=%h exp=%h", got, exp); end
    @(negedge CLK_Mod);
    got = {Mod_Valid_OUT, MOD_DONE, Sym_Count};
    exp = {1'b0, 1'b1, 11'd1};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL bpsk_after got=%h exp=%h", got, exp); end
    @(negedge CLK_Mod);
  endtask

  task automatic test_block_wrap();
    logic signed [17:0] ei, eq;
    apply_reset();
    Order_Mod = 4'd2;
    for (int k = 0; k < 10; k++) begin
      send_bits({6'b0, k[1], k[0]}, 2);
      ei = k[0] ? N724 : P724;
      eq = k[1] ? N724 : P724;
      got = {Mod_Valid_OUT, Mod_OUT_I, Mod_OUT_Q, Wr_addr, Bank_Sel, MOD_DONE};
      exp = {1'b1, ei, eq, 11'(k % 4), ((k / 4) % 2) == 1, (k % 4) == 3};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL wrap_sym%0d got=%h exp=%h", k, got, exp); end
      if (k % 4 == 3) begin
        n_checks++;
        if (Sym_Count !== 11'd4) begin n_fail++; $display("FAIL wrap_count%0d got=%0d exp=4", k, Sym_Count); end
      end
    end
    Valid_Mod_IN = 1'b0;
    @(negedge CLK_Mod);
    got = {MOD_DONE, Sym_Count, Bank_Sel};
    exp = {1'b1, 11'd2, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL wrap_final got=%h exp=%h", got, exp); end
    @(negedge CLK_Mod);
  endtask

  task automatic test_backpressure();
    apply_reset();
    Order_Mod = 4'd2;
    for (int k = 0; k < 4; k++) send_bits(8'b00, 2);
    Bank_Free = 2'b01;
    Valid_Mod_IN = 1'b1; Bit_IN = 1'b1;
    @(negedge CLK_Mod); #1;
    got = {Ready_Mod_OUT, Bank_Sel};
    exp = {1'b0, 1'b1};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL bp_stall got=%h exp=%h", got, exp); end
    repeat (3) @(negedge CLK_Mod);
    #1;
    got = {Ready_Mod_OUT, Mod_Valid_OUT};
    exp = '0;
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL bp_hold got=%h exp=%h", got, exp); end
    Bank_Free = 2'b11;
    send_bits(8'b11, 2);
    got = {Mod_Valid_OUT, Mod_OUT_I, Mod_OUT_Q, Wr_addr, Bank_Sel};
    exp = {1'b1, N724, N724, 11'd0, 1'b1};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL bp_sym got=%h exp=%h", got, exp); end
    Valid_Mod_IN = 1'b0;
    @(negedge CLK_Mod);
    got = {MOD_DONE, Sym_Count};
    exp = {1'b1, 11'd1};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL bp_done got=%h exp=%h", got, exp); end
    @(negedge CLK_Mod);
  endtask

  task automatic test_order_err();
    apply_reset();
    Order_Mod = 4'd3;
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1);
      n_checks++;
      if (Mod_Valid_OUT !== 1'b0) begin n_fail++; $display("FAIL oerr_valid%0d got=%0b exp=0", i, Mod_Valid_OUT); end
    end
    n_checks++;
    if (Order_Err !== 1'b1) begin n_fail++; $display("FAIL oerr_flag got=%0b exp=1", Order_Err); end
    Valid_Mod_IN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK_Mod);
      got = {MOD_DONE, Bank_Sel};
      exp = '0;
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL oerr_nodone%0d got=%h exp=%h", i, got, exp); end
    end
    Order_Mod = 4'd2;
    send_bits(8'b00, 2);
    got = {Mod_Valid_OUT, Mod_OUT_I, Wr_addr, Order_Err};
    exp = {1'b1, P724, 11'd0, 1'b1};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL oerr_recover got=%h exp=%h", got, exp); end
    Valid_Mod_IN = 1'b0;
    repeat (2) @(negedge CLK_Mod);
  endtask

  task automatic test_truncated();
    apply_reset();
    n_checks++;
    if (Order_Err !== 1'b0) begin n_fail++; $display("FAIL trunc_clear got=%0b exp=0", Order_Err); end
    Order_Mod = 4'd4;
    send_bits(8'b0000, 4);
    got = {Mod_Valid_OUT, Mod_OUT_I, Mod_OUT_Q, Wr_addr};
    exp = {1'b1, P324, P324, 11'd0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL trunc_sym got=%h exp=%h", got, exp); end
    send_bits(8'b00, 2);
    Valid_Mod_IN = 1'b0;
    @(negedge CLK_Mod);
    got = {MOD_DONE, Sym_Count, Order_Err};
    exp = {1'b1, 11'd1, 1'b1};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL trunc_done got=%h exp=%h", got, exp); end
    repeat (2) @(negedge CLK_Mod);
  endtask

  task automatic test_reset_mid();
    Order_Mod = 4'd2;
    send_bits(8'b00, 2);
    send_bit(1'b1);
    RST_Mod = 1'b0;
    #1;
    got = {Mod_Valid_OUT, Mod_OUT_I, Mod_OUT_Q, Wr_addr, Bank_Sel, MOD_DONE, Sym_Count, Order_Err};
    exp = '0;
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL rstmid_outputs got=%h exp=%h", got, exp); end
    Valid_Mod_IN = 1'b0;
    repeat (2) @(negedge CLK_Mod);
    RST_Mod = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK_Mod);
      n_checks++;
      if (MOD_DONE !== 1'b0) begin n_fail++; $display("FAIL rstmid_nodone%0d got=%0b exp=0", i, MOD_DONE); end
    end
    send_bits(8'b11, 2);
    got = {Mod_Valid_OUT, Mod_OUT_I, Mod_OUT_Q, Wr_addr, Bank_Sel};
    exp = {1'b1, N724, N724, 11'd0, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL rstmid_restart got=%h exp=%h", got, exp); end
    Valid_Mod_IN = 1'b0;
    repeat (2) @(negedge CLK_Mod);
  endtask

  initial begin
    test_reset();
    test_qpsk();
    test_16qam();
    test_64qam();
    test_256qam();
    test_bpsk();
    test_block_wrap();
    test_backpressure();
    test_order_err();
    test_truncated();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
